m_div_sequencer: RTL
====================

// Module: m_div_sequencer
// PURPOSE
//  Issue/complete control for RV32M DIV/DIVU/REM/REMU. Accepts one request from the execute stage,
//  resolves divide-by-zero and signed overflow locally, and otherwise launches the iterative
//  Division core and waits for it. It selects quotient or remainder and returns the result
//  with its destination tag. Back-to-back DIV/REM on identical operands is served from a
//  result cache without relaunching the core.
// PARAMETERS
//  XLEN       32  operand/result width; must equal the Division core INPUT_WIDTH
//  TAG_WIDTH  5   width of the opaque tag (rd index) carried from request to response
// PORTS
//  CLK            in   1          clock, rising edge
//  RST            in   1          asynchronous, active-high reset
//  STALL          in   1          pipeline stall; freezes all state here and in the core
//  FLUSH          in   1          abort any in-flight request; no response is produced
//  IN_VALID       in   1          request valid
//  IN_READY       out  1          request accepted when IN_VALID&IN_READY at a CLK edge
//  IN_FUNCT3      in   3          bit0=1 unsigned, bit1=1 remainder; bit2 ignored
//  IN_RS1         in   XLEN       dividend
//  IN_RS2         in   XLEN       divisor
//  IN_TAG         in   TAG_WIDTH  returned unchanged on OUT_TAG
//  OUT_VALID      out  1          response valid; held until OUT_READY
//  OUT_READY      in   1          consumer takes response
//  OUT_RESULT     out  XLEN       quotient or remainder
//  OUT_TAG        out  TAG_WIDTH  tag of the response
//  DIV_START      out  1          one-cycle launch pulse to core START
//  DIV_SIGN       out  1          core SIGN; held for the whole operation
//  DIV_DIVIDEND   out  XLEN       core DIVIDEND; registered, held stable until DONE exits
//  DIV_DIVIDER    out  XLEN       core DIVIDER; registered, held stable until DONE exits
//  DIV_STALL      out  1          core STALL_DIV; equals STALL
//  DIV_QUOTIENT   in   XLEN       core QUOTIENT_OUT
//  DIV_REMAINDER  in   XLEN       core REMAINDER_OUT
//  DIV_READY      in   1          core READY (high when idle/finished)
// BEHAVIOUR
//  Reset: state=IDLE, OUT_VALID=0, OUT_RESULT=0, OUT_TAG=0, DIV_START=0, DIV_SIGN=0.
//   Also DIV_DIVIDEND=DIV_DIVIDER=0 and cache_valid=0. RST is held for >=1 CLK edge so the
//   core's synchronous reset is seen.
//  IN_READY = (state==IDLE) & !STALL & !FLUSH. STALL=1: no register changes anywhere.
//  FLUSH (not stalled): next state IDLE, OUT_VALID=0; overrides all other events incl. accept.
//  FSM IDLE->LAUNCH->WAIT->DONE->IDLE; IDLE->DONE directly for special case or cache hit.
//  IDLE on accept: latch rs1/rs2/tag/funct3, DIV_SIGN=!funct3[0]. Classify in priority order:
//   a) rs2==0: result = rem ? rs1 : all-ones; go to DONE
//   b) signed & rs1==1<<(XLEN-1) & rs2==all-ones: result = rem ? 0 : rs1; go to DONE
//   c) cache hit (cache_valid & rs1,rs2,sign equal cached): result = cached q or r; DONE
//   d) else: go to LAUNCH
//  LAUNCH: DIV_START=1 for exactly this cycle; next WAIT.
//  WAIT: DIV_START=0; core READY is low from the first WAIT cycle.
//   When DIV_READY=1: capture q/r, fill cache (cache_valid=1), select result, go to DONE.
//  DONE: OUT_VALID=1, OUT_RESULT/OUT_TAG stable. On OUT_VALID&OUT_READY go to IDLE.
//   No new accept in that same cycle.
//  Latency from accept edge to OUT_VALID high (no stall): a/b/c 1 cycle; d XLEN+2 (34) cycles.
//  Signed remainder takes the sign of the dividend; signed quotient truncates toward zero.
//   Both come from the core; no correction is applied here.
//  A flushed launch may leave the core running; the next DIV_START restarts it (START has priority).
//   The cache is not updated by a flushed operation.
// TESTING
//  DIVU 100/7, OUT_READY=1 -> OUT_RESULT=14 exactly 34 cycles after accept, OUT_TAG echoed.
//  DIV 0xFFFFFF9C(-100)/7, then REM same operands -> -14 (0xFFFFFFF2) in 34 cycles.
//   The REM returns -2 (0xFFFFFFFE) in 1 cycle (cache hit), DIV_START not pulsed.
//  DIV x/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
//   REM of the same overflow operands -> 0. All in 1 cycle with no DIV_START pulse.
//  STALL held 10 cycles in the middle of WAIT -> result correct, latency 34+10.
//   OUT_VALID held while OUT_READY=0, and no accept occurs until the response is taken.
//  FLUSH at WAIT cycle 5, then DIVU 9/2 -> no response for the flushed op; new result 4 after 34.
//  RST asserted mid-WAIT -> OUT_VALID=0, IN_READY=1 after release, cache miss on repeat operands.

Source files
------------

// File: rtl/m_div_sequencer.sv
// m_div_sequencer: RV32M DIV/DIVU/REM/REMU issue/complete control around an iterative divide core.
// Divide-by-zero and signed overflow are resolved locally; the last core result is cached for reuse.
module m_div_sequencer #(
  parameter int XLEN      = 32,
  parameter int TAG_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall_i,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [2:0]           in_funct3_i,
  input  logic [XLEN-1:0]      in_rs1_i,
  input  logic [XLEN-1:0]      in_rs2_i,
  input  logic [TAG_WIDTH-1:0] in_tag_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [XLEN-1:0]      out_result_o,
  output logic [TAG_WIDTH-1:0] out_tag_o,
  output logic                 div_start_o,
  output logic                 div_sign_o,
  output logic [XLEN-1:0]      div_dividend_o,
  output logic [XLEN-1:0]      div_divider_o,
  output logic                 div_stall_o,
  input  logic [XLEN-1:0]      div_quotient_i,
  input  logic [XLEN-1:0]      div_remainder_i,
  input  logic                 div_ready_i
);
  typedef enum logic [1:0] {IDLE, LAUNCH, S_WAIT, DONE} state_t;
  state_t          state_q;
  logic            rem_q, cache_valid_q, c_sign_q;
  logic [XLEN-1:0] cq_q, cr_q, c_rs1_q, c_rs2_q;
  logic            sign_in, is_zero, is_ovf, is_hit, unused_f3;
  logic [XLEN-1:0] fast_res;
  assign unused_f3   = in_funct3_i[2];
  assign sign_in     = !in_funct3_i[0];
  assign is_zero     = in_rs2_i == '0;
  assign is_ovf      = sign_in && in_rs1_i == {1'b1, {(XLEN-1){1'b0}}} && in_rs2_i == '1;
  assign is_hit      = cache_valid_q && in_rs1_i == c_rs1_q && in_rs2_i == c_rs2_q && sign_in == c_sign_q;
  assign fast_res    = is_zero ? (in_funct3_i[1] ? in_rs1_i : '1) :
                       is_ovf  ? (in_funct3_i[1] ? '0 : in_rs1_i) :
                                 (in_funct3_i[1] ? cr_q : cq_q);
  assign in_ready_o  = state_q == IDLE && !stall_i && !flush_i;
  assign div_stall_o = stall_i;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      out_valid_o    <= 1'b0;
      out_result_o   <= '0;
      out_tag_o      <= '0;
      div_start_o    <= 1'b0;
      div_sign_o     <= 1'b0;
      div_dividend_o <= '0;
      div_divider_o  <= '0;
      rem_q          <= 1'b0;
      cache_valid_q  <= 1'b0;
      c_sign_q       <= 1'b0;
      cq_q           <= '0;
      cr_q           <= '0;
      c_rs1_q        <= '0;
      c_rs2_q        <= '0;
    end else if (!stall_i) begin
      if (flush_i) begin
        state_q     <= IDLE;
        out_valid_o <= 1'b0;
        div_start_o <= 1'b0;
      end else begin
        case (state_q)
          IDLE: if (in_valid_i) begin
            div_dividend_o <= in_rs1_i;
            div_divider_o  <= in_rs2_i;
            out_tag_o      <= in_tag_i;
            rem_q          <= in_funct3_i[1];
            div_sign_o     <= sign_in;
            if (is_zero || is_ovf || is_hit) begin
              out_result_o <= fast_res;
              out_valid_o  <= 1'b1;
              state_q      <= DONE;
            end else begin
              div_start_o <= 1'b1;
              state_q     <= LAUNCH;
            end
          end
          LAUNCH: begin
            div_start_o <= 1'b0;
            state_q     <= S_WAIT;
          end
          S_WAIT: if (div_ready_i) begin
            cq_q          <= div_quotient_i;
            cr_q          <= div_remainder_i;
            c_rs1_q       <= div_dividend_o;
            c_rs2_q       <= div_divider_o;
            c_sign_q      <= div_sign_o;
            cache_valid_q <= 1'b1;
            out_result_o  <= rem_q ? div_remainder_i : div_quotient_i;
            out_valid_o   <= 1'b1;
            state_q       <= DONE;
          end
          default: if (out_ready_i) begin
            out_valid_o <= 1'b0;
            state_q     <= IDLE;
          end
        endcase
      end
    end
  end
endmodule
